// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line in, FIFO read port and sticky error flags out.
interface uart_rx_if;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       clr_err;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx, rd_en, clr_err,
    input  rd_data, rd_valid, frame_err, overrun, parity_err
  );

  modport slave (
    input  rx, rd_en, clr_err,
    output rd_data, rd_valid, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small FWFT FIFO.
// Framing, overrun and parity errors are sticky until clr_err.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low on a tick
// S_START  | confirming start bit at its middle; high there is a glitch
// S_DATA   | sampling 8 data bits LSB-first at bit centre
// S_PARITY | sampling even-parity bit (UART_RX_PARITY_EN builds only)
// S_STOP   | sampling stop bit; good byte pushed, low stop is framing error
// S_BREAK  | line held low after framing error, waiting for it to go high
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW     = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic [DW-1:0]  div_q, div_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     bc_q, bc_d;
  logic [7:0]     sh_q, sh_d;
  logic           par_bad_q, par_bad_d;
  logic           frame_err_q, overrun_q, parity_err_q;
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic rx_s, tick;
  logic push_req, frame_set, parity_set;
  logic fifo_empty, fifo_full, do_push, do_pop, ovr_set;

  assign rx_s = sync_q[1];
  assign tick = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    bc_d       = bc_q;
    sh_d       = sh_q;
    par_bad_d  = par_bad_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && !rx_s) begin
          state_d = S_START;
          sc_d    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              sc_d      = '0;
              bc_d      = '0;
              par_bad_d = 1'b0;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            sh_d = {rx_s, sh_q[7:1]};
            if (bc_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bc_d = bc_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            state_d = S_STOP;
            // Even parity: data ones plus parity bit must be even.
            if (rx_s != (^sh_q)) begin
              par_bad_d  = 1'b1;
              parity_set = 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (rx_s) begin
              push_req = !par_bad_q;
              state_d  = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_BREAK;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop     = bus.rd_en && !fifo_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovr_set    = push_req && fifo_full && !do_pop;

  assign bus.rd_valid   = !fifo_empty;
  assign bus.rd_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      div_q        <= '0;
      sc_q         <= '0;
      bc_q         <= '0;
      sh_q         <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], bus.rx};
      div_q        <= div_d;
      sc_q         <= sc_d;
      bc_q         <= bc_d;
      sh_q         <= sh_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_set  | (frame_err_q  & ~bus.clr_err);
      overrun_q    <= ovr_set    | (overrun_q    & ~bus.clr_err);
      parity_err_q <= parity_set | (parity_err_q & ~bus.clr_err);
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= sh_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: constant-table frames, hand-timed corner sequences and random bytes vs a queue model.
module tb_uart_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic clk = 1'b0;
  logic rst_n;
  uart_rx_if bus ();

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_q[$];
  bit model_ovr = 1'b0;
`ifdef UART_RX_PARITY_EN
  bit flip_par = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after a negedge; every line level lasts a whole number of clocks.
  task automatic send_frame(input logic [7:0] d, input bit stop_lvl = 1'b1, input int stop_len = 16);
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^d) ^ flip_par;
    repeat (16) @(negedge clk);
`endif
    bus.rx = stop_lvl;
    repeat (stop_len) @(negedge clk);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  function automatic void model_rx(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic pop_chk(input string name);
    if (model_q.size() == 0) begin
      chk({name, "_empty"}, bus.rd_valid, 0);
    end else begin
      chk({name, "_valid"}, bus.rd_valid, 1);
      chk({name, "_data"}, bus.rd_data, model_q[0]);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      void'(model_q.pop_front());
    end
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rd_valid"}, bus.rd_valid, 0);
    chk({name, "_rd_data"}, bus.rd_data, 0);
    chk({name, "_frame_err"}, bus.frame_err, 0);
    chk({name, "_overrun"}, bus.overrun, 0);
    chk({name, "_parity_err"}, bus.parity_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    int n;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1};

    bus.rx = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First byte and the delay from start edge to rd_valid.
    lat = -1;
    fork
      send_frame(8'hA5);
      begin
        for (int c = 1; c <= 200; c++) begin
          @(negedge clk);
          if (bus.rd_valid && lat < 0) lat = c;
        end
      end
    join
    chk("t1_latency_in_window", (lat >= LAT - 5 && lat <= LAT + 10), 1);
    chk("t1_frame_err", bus.frame_err, 0);
    chk("t1_overrun", bus.overrun, 0);
    model_rx(8'hA5);
    pop_chk("t1_pop");
    chk("t1_after_pop_valid", bus.rd_valid, 0);

    // Short low glitch must not start a frame.
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t2_glitch_valid", bus.rd_valid, 0);
    chk("t2_glitch_ferr", bus.frame_err, 0);
    send_frame(8'h3C);
    model_rx(8'h3C);
    pop_chk("t2_next");

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].stop_ok ? 16 : 40);
      chk($sformatf("vec%0d_valid", i), bus.rd_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), bus.rd_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_ferr", i), bus.frame_err, vecs[i].exp_ferr);
      if (vecs[i].exp_valid) begin
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
      clr_pulse();
      chk($sformatf("vec%0d_cleared", i), bus.frame_err | bus.rd_valid, 0);
    end

    // Held-low stop: clear while still low; line staying low must not re-flag.
    fork
      send_frame(8'h3C, 1'b0, 40);
      begin
        repeat (LAT + 10) @(negedge clk);
        chk("t3_ferr_set", bus.frame_err, 1);
        clr_pulse();
        repeat (10) @(negedge clk);
        chk("t3_single_error", bus.frame_err, 0);
      end
    join
    chk("t3_fifo_empty", bus.rd_valid, 0);
    send_frame(8'h55);
    model_rx(8'h55);
    pop_chk("t3_next");

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i));
      model_rx(8'(i));
    end
    chk("t4_overrun", bus.overrun, model_ovr);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("t4_pop%0d", i));
    chk("t4_drained", bus.rd_valid, 0);
    clr_pulse();
    model_ovr = 1'b0;
    chk("t4_ovr_cleared", bus.overrun, 0);

    // Full FIFO: pop in the very clock the fifth byte is pushed.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i));
      model_rx(8'h10 + 8'(i));
    end
    fork
      send_frame(8'h14);
      begin
        repeat (LAT - 1) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_rx(8'h14);
    chk("full_pushpop_no_overrun", bus.overrun, 0);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("full_pushpop_pop%0d", i));
    chk("full_pushpop_drained", bus.rd_valid, 0);

    // Reset in the middle of a frame with a byte waiting.
    send_frame(8'h33);
    fork
      send_frame(8'hFF);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_midframe_reset");
      end
    join
    model_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h12);
    model_rx(8'h12);
    pop_chk("t5_after");
    chk("t5_after_empty", bus.rd_valid, 0);

    // Random bytes with random reads against the queue model.
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send_frame(b);
      model_rx(b);
      chk($sformatf("rnd%0d_valid", i), bus.rd_valid, (model_q.size() != 0));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) pop_chk($sformatf("rnd%0d_pop", i));
    end
    chk("rnd_overrun", bus.overrun, model_ovr);
    while (model_q.size() != 0) pop_chk("rnd_drain");
    chk("rnd_drained", bus.rd_valid, 0);
    clr_pulse();
    model_ovr = 1'b0;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07);
    chk("t6_good_par_valid", bus.rd_valid, 1);
    chk("t6_good_par_data", bus.rd_data, 8'h07);
    chk("t6_good_par_err", bus.parity_err, 0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    flip_par = 1'b1;
    send_frame(8'h07);
    flip_par = 1'b0;
    chk("t6_bad_par_dropped", bus.rd_valid, 0);
    chk("t6_bad_par_err", bus.parity_err, 1);
    chk("t6_bad_par_no_ferr", bus.frame_err, 0);
    clr_pulse();
    chk("t6_par_cleared", bus.parity_err, 0);
`else
    chk("parity_err_tied", bus.parity_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
